hd44780_bus_responder: RTL
==========================

Name: hd44780_bus_responder

Overview:
- Responder end of the HD44780-style 8-bit parallel LCD bus that the team's clock/LCD writers drive.
- Samples lcd_e/lcd_rs/lcd_rw/lcd_data and decodes instructions and data writes.
- Maintains the address counter (AC), display flags and a 2x16 visible DDRAM mirror.
- Used as a bench/FPGA stand-in for the panel and as a frame source for secondary displays through a registered read port.

Parameters:
- BUSY_SHORT, 4: busy cycles after any non-clear/home instruction or data write.
- BUSY_LONG, 160: busy cycles after clear or return-home; must be >= 32.
- SYNC_STAGES, 2: synchronizer depth on all lcd_* inputs; minimum 2.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- resetn  in  1  reset, asynchronous, active-low.
- lcd_e  in  1  enable strobe; transfer committed on its falling edge.
- lcd_rs  in  1  0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_data  in  8  bus data.
- rd_addr  in  5  mirror read address; [4] = line, [3:0] = column.
- rd_char  out  8  mirror character, registered, 1-cycle latency.
- busy  out  1  busy flag.
- ac  out  7  address counter.
- disp_on, cur_on, blink_on  out  1 each  display-control bits.
- inc_mode  out  1  entry-mode I/D bit.
- cmd_stb  out  1  1-cycle pulse per accepted transfer.
- err_stb  out  1  1-cycle pulse per dropped or illegal transfer.
- lcd_dout  out  8  read-back data (see Optional Feature).
- lcd_dout_oe  out  1  read-back drive enable.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, resetn).
- Input sampling: all lcd_* inputs pass through SYNC_STAGES flops. While synced e=1, rs/rw/data are re-captured every cycle. A synced 1->0 transition commits the last captured values (event cycle). Decode/update completes 1 cycle after the event; cmd_stb/err_stb fire in that cycle.
- Reset values: ac=0, inc_mode=1, disp_on=cur_on=blink_on=0, cmd_stb=err_stb=0, rd_char=0x20, lcd_dout=0, lcd_dout_oe=0, busy=1.
- FSM states: FILL, IDLE, BUSY.
- Reset enters FILL: writes 0x20 to mirror entries 0..31, one per cycle, for 32 cycles, then goes to IDLE with busy=0.
- Clear also enters FILL. Busy is held for BUSY_LONG in total, counted from the decode cycle; FILL completes within that count and the FSM then waits in BUSY.
- Event during FILL/BUSY: transfer dropped, err_stb pulses, no state change.
- Event in IDLE, rw=0, decoded by highest set bit of data:
  - 1aaaaaaa: set DDRAM address. Legal values are 0x00-0x27 and 0x40-0x67. Any other value: ac unchanged, err_stb.
  - 01xxxxxx: CGRAM address; accepted, ignored.
  - 001xxxxx function set, 0001xxxx shift: accepted, ignored.
  - 00001DCB: display control; D/C/B latched into disp_on/cur_on/blink_on.
  - 000001IS: entry mode; I latched into inc_mode. S ignored.
  - 0000001x: return home; ac=0; BUSY_LONG.
  - 00000001: clear; ac=0, inc_mode=1, FILL.
  - 0x00: no-op; cmd_stb pulses, no busy.
  - Data write (rs=1): if ac[5:0] <= 15, mirror[{ac[6],ac[3:0]}] = data; otherwise the write is discarded but ac still moves.
- AC move after every data write:
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x00->0x67, 0x40->0x27.
- Busy duration: every accepted instruction other than no-op, clear and home, and every data write, sets busy for BUSY_SHORT cycles starting the decode cycle.
- rw=1 events: handled per Optional Feature.
- Read port: rd_char = mirror[rd_addr] one cycle after rd_addr is presented. A same-cycle write to that entry returns the old value.
- resetn low at any time: immediate reset values and a restarted FILL.

Optional Feature:
- Macro: LCD_READBACK_EN.
- Defined:
  - While synced e=1 and rw=1, lcd_dout_oe=1.
  - rs=0: lcd_dout={busy, ac}.
  - rs=1: lcd_dout=mirror entry at ac, or 0x20 if column > 15. On falling e, ac moves per entry mode. cmd_stb pulses.
- Undefined: lcd_dout=0 and lcd_dout_oe=0 constantly; rw=1 events are dropped with err_stb.

Test Plan:
- Reset release -> busy=1 for 32 cycles then 0; rd_addr 0..31 all read 0x20.
- Send 0x38,0x08,0x01,0x06,0x0C, each after busy clears -> disp_on=1, cur_on=0, inc_mode=1, ac=0, eleven... no err_stb, five cmd_stb.
- Send 0x80 then data "2024/01/01" -> rd_addr 0..9 read 0x32,0x30,0x32,0x34,0x2F,0x30,0x31,0x2F,0x30,0x31; ac=0x0A.
- Send 0xA7 then data 0x41 -> ac=0x40, no visible mirror change. Send 0xC0 then 0x39 -> rd_addr 16 reads 0x39.
- Data write while busy (1 cycle after clear) -> err_stb=1, mirror unchanged. Send 0xA8 -> err_stb, ac unchanged.
- With LCD_READBACK_EN: rw=1, rs=0 during BUSY_LONG -> lcd_dout[7]=1. With ac=0x00 and inc_mode=0, rw=1, rs=1 -> returns the char at entry 0; ac becomes 0x67.

Source files
------------

// File: rtl/hd44780_bus_responder.sv
// HD44780-style 8-bit parallel bus responder: decodes writes, tracks AC/flags and a 2x16 DDRAM mirror.
// Optional LCD_READBACK_EN adds busy/AC and DDRAM read-back on lcd_dout.
module hd44780_bus_responder #(
  parameter int BUSY_SHORT  = 4,
  parameter int BUSY_LONG   = 160,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cur_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       cmd_stb,
  output logic       err_stb,
  output logic [7:0] lcd_dout,
  output logic       lcd_dout_oe
);

  localparam int CW = $clog2(BUSY_LONG + 1);

  typedef enum logic [1:0] {FILL, IDLE, BUSY} state_t;

  state_t state, state_next;

  logic [10:0]   sync_q [SYNC_STAGES];
  logic          e_s, rs_s, rw_s;
  logic [7:0]    data_s;
  logic          e_prev;
  logic          cap_rs, cap_rw;
  logic [7:0]    cap_data;
  logic          ev;
  logic          accept, reject;
  logic          go_fill, go_long, go_short;
  logic          dd_legal;
  logic [CW-1:0] cnt;
  logic [4:0]    fill_idx;
  logic          fill_we;
  logic          data_we;
  logic [4:0]    wr_addr;
  logic [7:0]    mirror [32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign e_s    = sync_q[SYNC_STAGES-1][10];
  assign rs_s   = sync_q[SYNC_STAGES-1][9];
  assign rw_s   = sync_q[SYNC_STAGES-1][8];
  assign data_s = sync_q[SYNC_STAGES-1][7:0];

  // The falling edge of e commits whatever was captured while e was high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_prev   <= 1'b0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= '0;
    end else begin
      e_prev <= e_s;
      if (e_s) begin
        cap_rs   <= rs_s;
        cap_rw   <= rw_s;
        cap_data <= data_s;
      end
    end
  end

  assign ev       = e_prev & ~e_s;
  assign dd_legal = (cap_data[6:0] <= 7'h27) ||
                    ((cap_data[6:0] >= 7'h40) && (cap_data[6:0] <= 7'h67));

  always_comb begin
    accept   = 1'b0;
    reject   = 1'b0;
    go_fill  = 1'b0;
    go_long  = 1'b0;
    go_short = 1'b0;
    if (ev) begin
      if (state != IDLE) begin
        reject = 1'b1;
      end else if (cap_rw) begin
`ifdef LCD_READBACK_EN
        accept = 1'b1;
`else
        reject = 1'b1;
`endif
      end else if (cap_rs) begin
        accept   = 1'b1;
        go_short = 1'b1;
      end else if (cap_data[7]) begin
        accept   = dd_legal;
        reject   = ~dd_legal;
        go_short = dd_legal;
      end else if (cap_data == 8'h00) begin
        accept = 1'b1;
      end else if (cap_data == 8'h01) begin
        accept  = 1'b1;
        go_fill = 1'b1;
      end else if (cap_data[7:1] == 7'b0000001) begin
        accept  = 1'b1;
        go_long = 1'b1;
      end else begin
        accept   = 1'b1;
        go_short = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= FILL;
    else         state <= state_next;
  end

  // FILL always runs 32 cycles; the shared counter decides whether busy outlasts it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (go_fill)                  state_next = FILL;
        else if (go_long || go_short) state_next = BUSY;
      end
      FILL: begin
        if (fill_idx == 5'd31) state_next = (cnt == '0) ? IDLE : BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    fill_we = (state == FILL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= CW'(31);
      fill_idx <= '0;
    end else begin
      if (go_fill || go_long) cnt <= CW'(BUSY_LONG - 1);
      else if (go_short)      cnt <= CW'(BUSY_SHORT - 1);
      else if (cnt != '0)     cnt <= cnt - 1'b1;
      if (go_fill)            fill_idx <= '0;
      else if (state == FILL) fill_idx <= fill_idx + 1'b1;
    end
  end

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ac       <= '0;
      inc_mode <= 1'b1;
      disp_on  <= 1'b0;
      cur_on   <= 1'b0;
      blink_on <= 1'b0;
      cmd_stb  <= 1'b0;
      err_stb  <= 1'b0;
    end else begin
      cmd_stb <= accept;
      err_stb <= reject;
      if (accept) begin
        if (cap_rs) begin
          ac <= ac_step(ac, inc_mode);
        end else if (!cap_rw) begin
          if (cap_data[7]) begin
            ac <= cap_data[6:0];
          end else if (cap_data[7:3] == 5'b00001) begin
            {disp_on, cur_on, blink_on} <= cap_data[2:0];
          end else if (cap_data[7:2] == 6'b000001) begin
            inc_mode <= cap_data[1];
          end else if (cap_data[7:1] == 7'b0000001) begin
            ac <= '0;
          end else if (cap_data == 8'h01) begin
            ac       <= '0;
            inc_mode <= 1'b1;
          end
        end
      end
    end
  end

  // Only columns 0..15 of each line are mirrored; other DDRAM writes just move AC.
  assign data_we = accept & cap_rs & ~cap_rw & (ac[5:0] <= 6'd15);
  assign wr_addr = {ac[6], ac[3:0]};

  always_ff @(posedge clk) begin
    if (fill_we)      mirror[fill_idx] <= 8'h20;
    else if (data_we) mirror[wr_addr]  <= cap_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_char <= 8'h20;
    else         rd_char <= mirror[rd_addr];
  end

`ifdef LCD_READBACK_EN
  logic [7:0] rb_char;

  assign rb_char = (ac[5:0] <= 6'd15) ? mirror[{ac[6], ac[3:0]}] : 8'h20;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lcd_dout    <= '0;
      lcd_dout_oe <= 1'b0;
    end else begin
      lcd_dout_oe <= e_s & rw_s;
      if (e_s & rw_s) lcd_dout <= rs_s ? rb_char : {busy, ac};
      else            lcd_dout <= '0;
    end
  end
`else
  assign lcd_dout    = '0;
  assign lcd_dout_oe = 1'b0;
`endif

endmodule
